// File: rtl/router_fsm.sv
// Input-side control FSM of the 1x3 router: header decode, payload load,
// full-FIFO stalling and parity capture, with per-port timeout soft reset.
module router_fsm (
    input  logic       clk,
    input  logic       resetn,
    input  logic       packet_valid,
    input  logic [1:0] datain,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] addr_sel
);

    typedef enum logic [2:0] {
        ST_DA  = 3'd0,
        ST_LFD = 3'd1,
        ST_LD  = 3'd2,
        ST_LP  = 3'd3,
        ST_CPE = 3'd4,
        ST_FFS = 3'd5,
        ST_LAF = 3'd6,
        ST_WTE = 3'd7
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] addr_sel_q;
    logic [1:0] addr_sel_d;
    logic [2:0] empty_vec_s;
    logic [2:0] soft_vec_s;
    logic       empty_hdr_s;
    logic       empty_sel_s;
    logic       soft_sel_s;

    // Port select over the three destinations; address 3 selects nothing.
    function automatic logic pick3(input logic [2:0] vec, input logic [1:0] idx);
        logic bit_v;
        case (idx)
            2'd0:    bit_v = vec[0];
            2'd1:    bit_v = vec[1];
            2'd2:    bit_v = vec[2];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    assign empty_vec_s = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_vec_s  = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign empty_hdr_s = pick3(empty_vec_s, datain);
    assign empty_sel_s = pick3(empty_vec_s, addr_sel_q);
    assign soft_sel_s  = pick3(soft_vec_s, addr_sel_q);
    assign addr_sel    = addr_sel_q;

    // State and address registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_DA;
            addr_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_sel_q <= addr_sel_d;
        end
    end

    // Next-state selection; a timeout on the selected port overrides everything.
    always_comb begin
        state_d    = state_q;
        addr_sel_d = addr_sel_q;
        if ((state_q != ST_DA) && soft_sel_s) begin
            state_d = ST_DA;
        end else begin
            case (state_q)
                ST_DA: begin
                    if (packet_valid && (datain != 2'b11)) begin
                        addr_sel_d = datain;
                        state_d    = empty_hdr_s ? ST_LFD : ST_WTE;
                    end else begin
                        state_d = ST_DA;
                    end
                end
                ST_WTE:  state_d = empty_sel_s ? ST_LFD : ST_WTE;
                ST_LFD:  state_d = ST_LD;
                ST_LD: begin
                    if (fifo_full) begin
                        state_d = ST_FFS;
                    end else if (!packet_valid) begin
                        state_d = ST_LP;
                    end else begin
                        state_d = ST_LD;
                    end
                end
                ST_FFS:  state_d = fifo_full ? ST_FFS : ST_LAF;
                ST_LAF: begin
                    if (parity_done) begin
                        state_d = ST_DA;
                    end else if (low_packet_valid) begin
                        state_d = ST_LP;
                    end else begin
                        state_d = ST_LD;
                    end
                end
                ST_LP:   state_d = ST_CPE;
                ST_CPE:  state_d = fifo_full ? ST_FFS : ST_DA;
                default: state_d = ST_DA;
            endcase
        end
    end

    // Strobes are a pure decode of the registered state.
    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        full_state    = 1'b0;
        laf_state     = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        busy          = 1'b1;
        case (state_q)
            ST_DA: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            ST_LFD: begin
                lfd_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_LD: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            ST_LP:   write_enb_reg = 1'b1;
            ST_CPE:  rst_int_reg   = 1'b1;
            ST_FFS:  full_state    = 1'b1;
            ST_LAF: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            ST_WTE:  busy = 1'b1;
            default: busy = 1'b1;
        endcase
    end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control state machine for the 1x3 router input side.
- Sequences header decode, payload load, FIFO-full stalling and parity capture.
- Drives the state strobes consumed by the register/parity datapath (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the write enable toward the synchronizer/FIFOs.
- Holds off the source via busy while a packet cannot be accepted.

Parameters:
- None. Three destination ports are fixed by the 2-bit header address; address 2'b11 is invalid.

Ports:
- clk  input  1  system clock, all state on rising edge
- resetn  input  1  synchronous active-low reset
- packet_valid  input  1  source asserts for header+payload bytes; deasserts on parity byte
- datain  input  2  header address bits [1:0], sampled in DECODE_ADDRESS
- fifo_full  input  1  selected destination FIFO full (from synchronizer)
- fifo_empty_0/1/2  input  1 each  destination FIFO empty flags
- soft_reset_0/1/2  input  1 each  per-port timeout soft reset
- parity_done  input  1  datapath has captured the parity byte
- low_packet_valid  input  1  datapath saw packet_valid drop during load
- detect_add  output  1  high in DECODE_ADDRESS
- lfd_state  output  1  high in LOAD_FIRST_DATA
- ld_state  output  1  high in LOAD_DATA
- full_state  output  1  high in FIFO_FULL_STATE
- laf_state  output  1  high in LOAD_AFTER_FULL
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR
- write_enb_reg  output  1  high in LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL
- busy  output  1  high in every state except DECODE_ADDRESS and LOAD_DATA
- addr_sel  output  2  latched destination address

Behaviour:
- Eight states: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE).
- All outputs are a pure decode of the registered state, except addr_sel, which is a register. No input-to-output combinational path.
- Reset (resetn=0 at clk edge): state=DA, addr_sel=0. Resulting outputs: detect_add=1, all other strobes 0, busy=0, write_enb_reg=0.
- DA:
  - packet_valid=1 and datain!=3: latch addr_sel<=datain. Go to LFD if fifo_empty[datain]=1, else WTE.
  - packet_valid=0 or datain==3: stay; addr_sel unchanged.
- WTE: go to LFD when fifo_empty[addr_sel]=1, else stay.
- LFD: go to LD unconditionally (one cycle; header written).
- LD, in priority order:
  - fifo_full=1 -> FFS
  - else packet_valid=0 -> LP
  - else stay
- FFS: stay while fifo_full=1; go to LAF on the first cycle fifo_full=0.
- LAF, in priority order:
  - parity_done=1 -> DA
  - else low_packet_valid=1 -> LP
  - else LD
- LP: go to CPE unconditionally.
- CPE: fifo_full=1 -> FFS; else DA.
- Soft reset: in any state other than DA, soft_reset_[addr_sel]=1 forces next state DA.
  - Priority: resetn, then soft reset, then normal transitions.
  - Soft resets of non-selected ports are ignored.
  - addr_sel holds its value.
- Simultaneous events:
  - fifo_full and packet_valid=0 in LD: FFS wins, and the parity byte is taken via the LAF path.
  - Soft reset and fifo_full together: soft reset wins.
- Latency: header accepted in DA -> write_enb_reg high the next cycle (LFD) when the FIFO is empty.
- busy=1 in LFD stalls the source one cycle after the header; busy drops in LD.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, then packet_valid=0 -> state DA, detect_add=1, busy=0, write_enb_reg=0, addr_sel=0.
- Normal packet to port 1: datain=2'b01, packet_valid=1, fifo_empty_1=1, 3 payload cycles, then packet_valid=0.
  - Expected sequence: DA -> LFD -> LD x3 -> LP -> CPE -> DA.
  - addr_sel=1; write_enb_reg high for 5 cycles (LFD, LD x3, LP).
  - rst_int_reg pulses exactly 1 cycle.
- Destination busy: datain=2'b10, fifo_empty_2=0 for 4 cycles, then 1.
  - Expected: WTE for 4 cycles with busy=1 and write_enb_reg=0, then LFD.
- FIFO full mid-payload: in LD assert fifo_full for 3 cycles.
  - Expected: FFS for 3 cycles (full_state=1, busy=1, write_enb_reg=0), then LAF.
  - With parity_done=0 and low_packet_valid=0: return to LD.
  - Repeat with low_packet_valid=1: LAF -> LP -> CPE.
- Soft reset: in LD with addr_sel=0, assert soft_reset_1 -> no effect. Then assert soft_reset_0 -> next state DA, detect_add=1.
- Invalid address: datain=2'b11, packet_valid=1 -> remain in DA, addr_sel unchanged, busy=0.
